// File: rtl/rdlvl_window_center.sv
// rdlvl_window_center: per-lane read-DQ delay sweep, pass-window search and centering.
// Optional build macro RDLVL_GLITCH_FILTER_EN: the right edge needs two consecutive failing taps.
module rdlvl_window_center #(
  parameter int NUM_LANES     = 9,
  parameter int DQ_WIDTH      = 8,
  parameter int TAP_W         = 7,
  parameter int READS_PER_TAP = 4,
  parameter int SETTLE_CYCLES = 3,
  parameter int MIN_WINDOW    = 8,
  localparam int SEL_W        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                            SCLK,
  input  logic                            reset,
  input  logic                            rdlvl_en,
  input  logic [7:0]                      training_pattern,
  input  logic [NUM_LANES*8*DQ_WIDTH-1:0] rddata,
  input  logic                            rddata_valid,
  input  logic [NUM_LANES-1:0]            rx_out_of_range,
  output logic [NUM_LANES-1:0]            rd_load,
  output logic [NUM_LANES-1:0]            rd_move,
  output logic [NUM_LANES-1:0]            rd_direction,
  output logic [NUM_LANES-1:0]            rdlvl_resp,
  output logic [NUM_LANES-1:0]            rd_training_error,
  output logic                            busy,
  input  logic [SEL_W-1:0]                res_lane_sel,
  output logic [TAP_W:0]                  res_center,
  output logic [TAP_W:0]                  res_window
);

  localparam int LANE_W  = 8 * DQ_WIDTH;
  localparam int TAP1_W  = TAP_W + 1;
  localparam int MAX_TAP = (1 << TAP_W) - 1;
  localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);
  localparam int RD_W    = $clog2(READS_PER_TAP + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL, S_STEP,
    S_CENTER, S_CSTEP, S_ELOAD, S_NEXT, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     cur_q, cur_d;
  logic [TAP1_W-1:0]    tap_q, tap_d;
  logic [TAP1_W-1:0]    left_q, left_d;
  logic [TAP1_W-1:0]    right_q, right_d;
  logic                 left_vld_q, left_vld_d;
  logic [SET_W-1:0]     settle_cnt_q, settle_cnt_d;
  logic [RD_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic                 fail_q, fail_d;
  logic                 lane_err_q, lane_err_d;
  logic                 centering_q, centering_d;
  logic                 en_prev_q, en_prev_d;
  logic                 busy_q, busy_d;
  logic [NUM_LANES-1:0] load_q, load_d;
  logic [NUM_LANES-1:0] move_q, move_d;
  logic [NUM_LANES-1:0] dir_q, dir_d;
  logic [NUM_LANES-1:0] resp_q, resp_d;
  logic [NUM_LANES-1:0] err_q, err_d;
  logic [TAP1_W-1:0]    center_mem_q [NUM_LANES];
  logic [TAP1_W-1:0]    center_mem_d [NUM_LANES];
  logic [TAP1_W-1:0]    window_mem_q [NUM_LANES];
  logic [TAP1_W-1:0]    window_mem_d [NUM_LANES];
  logic [TAP1_W-1:0]    res_center_q, res_center_d;
  logic [TAP1_W-1:0]    res_window_q, res_window_d;
`ifdef RDLVL_GLITCH_FILTER_EN
  logic                 pend_fail_q, pend_fail_d;
`endif

  logic [LANE_W-1:0]    lane_data;
  logic                 lane_mismatch;
  logic                 oor_cur;
  logic                 at_end;
  logic                 win_end;
  logic [NUM_LANES-1:0] cur_oh;
  logic [TAP1_W-1:0]    window_w;
  logic [TAP1_W-1:0]    center_w;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_LANES-1:0] oh;
    for (int l = 0; l < NUM_LANES; l++) oh[l] = (idx == SEL_W'(l));
    return oh;
  endfunction

  // Current-lane view of the read data and the out-of-range flag.
  always_comb begin
    lane_data = '0;
    oor_cur   = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (cur_q == SEL_W'(l)) begin
        lane_data = rddata[l*LANE_W +: LANE_W];
        oor_cur   = rx_out_of_range[l];
      end
    end
    lane_mismatch = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (lane_data[b*DQ_WIDTH +: DQ_WIDTH] != training_pattern[DQ_WIDTH-1:0]) lane_mismatch = 1'b1;
    end
    cur_oh   = lane_onehot(cur_q);
    window_w = right_q - left_q;
    center_w = left_q + (window_w >> 1);
    at_end   = (tap_q == TAP1_W'(MAX_TAP)) || oor_cur;
  end

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    tap_d        = tap_q;
    left_d       = left_q;
    right_d      = right_q;
    left_vld_d   = left_vld_q;
    settle_cnt_d = settle_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    fail_d       = fail_q;
    lane_err_d   = lane_err_q;
    centering_d  = centering_q;
    resp_d       = resp_q;
    err_d        = err_q;
    center_mem_d = center_mem_q;
    window_mem_d = window_mem_q;
    win_end      = 1'b0;
`ifdef RDLVL_GLITCH_FILTER_EN
    pend_fail_d  = pend_fail_q;
`endif
    if (!rdlvl_en) begin
      state_d = S_IDLE;
      resp_d  = '0;
      err_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!en_prev_q) begin
            cur_d   = '0;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          tap_d        = '0;
          left_vld_d   = 1'b0;
          lane_err_d   = 1'b0;
          centering_d  = 1'b0;
          settle_cnt_d = '0;
`ifdef RDLVL_GLITCH_FILTER_EN
          pend_fail_d  = 1'b0;
`endif
          state_d      = S_SETTLE;
        end
        S_SETTLE: begin
          rd_cnt_d = '0;
          fail_d   = 1'b0;
          if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
            state_d = centering_q ? S_CENTER : S_SAMPLE;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end
        S_SAMPLE: begin
          if (rddata_valid) begin
            fail_d = fail_q | lane_mismatch;
            if (rd_cnt_q == RD_W'(READS_PER_TAP - 1)) state_d = S_EVAL;
            else rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
        S_EVAL: begin
          if (!fail_q && !left_vld_q) begin
            left_d     = tap_q;
            left_vld_d = 1'b1;
          end
`ifdef RDLVL_GLITCH_FILTER_EN
          // A lone failing tap inside the window is treated as a glitch.
          if (left_vld_q && fail_q) begin
            if (pend_fail_q) begin
              right_d = tap_q - TAP1_W'(1);
              win_end = 1'b1;
            end else if (at_end) begin
              right_d = tap_q;
              win_end = 1'b1;
            end else begin
              pend_fail_d = 1'b1;
            end
          end else begin
            pend_fail_d = 1'b0;
          end
`else
          if (left_vld_q && fail_q) begin
            right_d = tap_q;
            win_end = 1'b1;
          end
`endif
          if (win_end) begin
            state_d = S_CENTER;
          end else if (at_end && !(left_vld_q && fail_q)) begin
            if (left_vld_d) begin
              right_d = tap_q + TAP1_W'(1);
              state_d = S_CENTER;
            end else begin
              lane_err_d = 1'b1;
              state_d    = S_ELOAD;
            end
          end else begin
            tap_d   = tap_q + TAP1_W'(1);
            state_d = S_STEP;
          end
        end
        S_STEP: begin
          settle_cnt_d = '0;
          state_d      = S_SETTLE;
        end
        S_CENTER: begin
          centering_d = 1'b1;
          if (tap_q == center_w) begin
            state_d = S_NEXT;
          end else begin
            tap_d   = tap_q - TAP1_W'(1);
            state_d = S_CSTEP;
          end
        end
        S_CSTEP: begin
          settle_cnt_d = '0;
          state_d      = S_SETTLE;
        end
        S_ELOAD: state_d = S_NEXT;
        S_NEXT: begin
          for (int l = 0; l < NUM_LANES; l++) begin
            if (cur_oh[l]) begin
              center_mem_d[l] = lane_err_q ? '0 : center_w;
              window_mem_d[l] = lane_err_q ? '0 : window_w;
            end
          end
          resp_d = resp_q | cur_oh;
          if (lane_err_q || (window_w < TAP1_W'(MIN_WINDOW))) err_d = err_q | cur_oh;
          if (cur_q == SEL_W'(NUM_LANES - 1)) begin
            state_d = S_DONE;
          end else begin
            cur_d   = cur_q + 1'b1;
            state_d = S_LOAD;
          end
        end
        S_DONE: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end

    // Delay-line controls are registered alongside the state they belong to.
    load_d = '0;
    move_d = '0;
    dir_d  = dir_q;
    if (state_d == S_LOAD || state_d == S_ELOAD) load_d = lane_onehot(cur_d);
    if (state_d == S_STEP) begin
      move_d = lane_onehot(cur_d);
      dir_d  = dir_q | lane_onehot(cur_d);
    end
    if (state_d == S_CSTEP) begin
      move_d = lane_onehot(cur_d);
      dir_d  = dir_q & ~lane_onehot(cur_d);
    end
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
    en_prev_d = rdlvl_en;

    res_center_d = '0;
    res_window_d = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (res_lane_sel == SEL_W'(l)) begin
        res_center_d = center_mem_q[l];
        res_window_d = window_mem_q[l];
      end
    end
  end

  always_ff @(posedge SCLK) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      tap_q        <= '0;
      left_q       <= '0;
      right_q      <= '0;
      left_vld_q   <= 1'b0;
      settle_cnt_q <= '0;
      rd_cnt_q     <= '0;
      fail_q       <= 1'b0;
      lane_err_q   <= 1'b0;
      centering_q  <= 1'b0;
      en_prev_q    <= 1'b0;
      busy_q       <= 1'b0;
      load_q       <= '0;
      move_q       <= '0;
      dir_q        <= '0;
      resp_q       <= '0;
      err_q        <= '0;
      center_mem_q <= '{default: '0};
      window_mem_q <= '{default: '0};
      res_center_q <= '0;
      res_window_q <= '0;
`ifdef RDLVL_GLITCH_FILTER_EN
      pend_fail_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      tap_q        <= tap_d;
      left_q       <= left_d;
      right_q      <= right_d;
      left_vld_q   <= left_vld_d;
      settle_cnt_q <= settle_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      fail_q       <= fail_d;
      lane_err_q   <= lane_err_d;
      centering_q  <= centering_d;
      en_prev_q    <= en_prev_d;
      busy_q       <= busy_d;
      load_q       <= load_d;
      move_q       <= move_d;
      dir_q        <= dir_d;
      resp_q       <= resp_d;
      err_q        <= err_d;
      center_mem_q <= center_mem_d;
      window_mem_q <= window_mem_d;
      res_center_q <= res_center_d;
      res_window_q <= res_window_d;
`ifdef RDLVL_GLITCH_FILTER_EN
      pend_fail_q  <= pend_fail_d;
`endif
    end
  end

  assign rd_load           = load_q;
  assign rd_move           = move_q;
  assign rd_direction      = dir_q;
  assign rdlvl_resp        = resp_q;
  assign rd_training_error = err_q;
  assign busy              = busy_q;
  assign res_center        = res_center_q;
  assign res_window        = res_window_q;

endmodule

// File: tb/tb_rdlvl_window_center.sv
// Directed bench for rdlvl_window_center: a per-lane delay-line model feeds read data from
// hand-chosen pass ranges; results, pulses and final taps are compared to hand-computed values.
module tb_rdlvl_window_center;
  localparam int NL   = 9;
  localparam int DQ   = 8;
  localparam int TAPW = 7;

  logic             SCLK = 1'b0;
  logic             reset;
  logic             rdlvl_en;
  logic [7:0]       training_pattern;
  logic [NL*8*DQ-1:0] rddata;
  logic             rddata_valid;
  logic [NL-1:0]    rx_out_of_range;
  logic [NL-1:0]    rd_load, rd_move, rd_direction, rdlvl_resp, rd_training_error;
  logic             busy;
  logic [3:0]       res_lane_sel;
  logic [TAPW:0]    res_center, res_window;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int tap_m    [NL] = '{default: 0};
  int load_cnt [NL] = '{default: 0};
  int mv_cnt   [NL] = '{default: 0};
  int dec_cnt  [NL] = '{default: 0};
  int lo [NL];
  int hi [NL];
  int hole [NL];
  int oor_at [NL];
  int exp_c [NL];
  int exp_w [NL];

  rdlvl_window_center dut (
    .SCLK(SCLK), .reset(reset), .rdlvl_en(rdlvl_en), .training_pattern(training_pattern),
    .rddata(rddata), .rddata_valid(rddata_valid), .rx_out_of_range(rx_out_of_range),
    .rd_load(rd_load), .rd_move(rd_move), .rd_direction(rd_direction),
    .rdlvl_resp(rdlvl_resp), .rd_training_error(rd_training_error), .busy(busy),
    .res_lane_sel(res_lane_sel), .res_center(res_center), .res_window(res_window)
  );

  always #5 SCLK = ~SCLK;

  // Delay line model: load returns to tap 0, move steps one tap in rd_direction.
  always @(posedge SCLK) begin
    cyc <= cyc + 1;
    for (int l = 0; l < NL; l++) begin
      if (rd_load[l]) begin
        tap_m[l]    <= 0;
        load_cnt[l] <= load_cnt[l] + 1;
      end else if (rd_move[l]) begin
        mv_cnt[l] <= mv_cnt[l] + 1;
        if (rd_direction[l]) tap_m[l] <= tap_m[l] + 1;
        else begin
          tap_m[l]   <= tap_m[l] - 1;
          dec_cnt[l] <= dec_cnt[l] + 1;
        end
      end
    end
  end

  assign rddata_valid = (cyc % 3) != 2;

  // Failing taps and invalid cycles corrupt one beat that moves with the tap.
  always_comb begin
    rddata          = '0;
    rx_out_of_range = '0;
    for (int l = 0; l < NL; l++) begin
      for (int b = 0; b < 8; b++) rddata[(l*8+b)*DQ +: DQ] = training_pattern;
      if (!rddata_valid || tap_m[l] < lo[l] || tap_m[l] > hi[l] || tap_m[l] == hole[l])
        rddata[(l*8 + (tap_m[l] & 7))*DQ +: DQ] = ~training_pattern;
      rx_out_of_range[l] = (tap_m[l] >= oor_at[l]);
    end
  end

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge SCLK);
      n++;
    end
    check("sweep_done_in_budget", busy, 0);
  endtask

  task automatic check_lanes(input string run);
    for (int l = 0; l < NL; l++) begin
      res_lane_sel = 4'(l);
      @(negedge SCLK);
      check($sformatf("%s_center%0d", run, l), res_center, exp_c[l]);
      check($sformatf("%s_window%0d", run, l), res_window, exp_w[l]);
      check($sformatf("%s_tap%0d", run, l), tap_m[l], exp_c[l]);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses_before;
    int pulses_after;
    reset = 1'b1;
    rdlvl_en = 1'b0;
    training_pattern = 8'hA5;
    res_lane_sel = '0;
    for (int l = 0; l < NL; l++) begin
      lo[l] = 20; hi[l] = 60; hole[l] = -1; oor_at[l] = 999;
      exp_c[l] = 40; exp_w[l] = 41;
    end
    lo[0] = 10;  hi[0] = 41;  exp_c[0] = 26;  exp_w[0] = 32;
    lo[2] = 200; hi[2] = -1;  exp_c[2] = 0;   exp_w[2] = 0;
    lo[3] = 30;  hi[3] = 34;  exp_c[3] = 32;  exp_w[3] = 5;
    lo[4] = 100; hi[4] = 127; exp_c[4] = 114; exp_w[4] = 28;
    lo[5] = 10;  hi[5] = 40;  hole[5] = 22;
`ifdef RDLVL_GLITCH_FILTER_EN
    exp_c[5] = 25; exp_w[5] = 31;
`else
    exp_c[5] = 16; exp_w[5] = 12;
`endif
    lo[6] = 40;  hi[6] = 60;  oor_at[6] = 50; exp_c[6] = 45; exp_w[6] = 11;

    repeat (3) @(negedge SCLK);
    check("rst_load", int'(rd_load), 0);
    check("rst_move", int'(rd_move), 0);
    check("rst_dir", int'(rd_direction), 0);
    check("rst_resp", int'(rdlvl_resp), 0);
    check("rst_err", int'(rd_training_error), 0);
    check("rst_busy", busy, 0);
    check("rst_center", res_center, 0);
    check("rst_window", res_window, 0);
    reset = 1'b0;

    @(negedge SCLK);
    rdlvl_en = 1'b1;
    @(negedge SCLK);
    check("start_busy", busy, 1);
    check("start_load_lane0", int'(rd_load), 1);
    wait_idle(20000);
    check("run1_resp", int'(rdlvl_resp), 'h1FF);
    check("run1_err", int'(rd_training_error), 'h00C);
    for (int l = 0; l < NL; l++)
      check($sformatf("run1_loads%0d", l), load_cnt[l], (l == 2) ? 2 : 1);
    check_lanes("run1");
`ifdef RDLVL_GLITCH_FILTER_EN
    check("dec_lane1", dec_cnt[1], 22);
    check("dec_lane3", dec_cnt[3], 4);
`else
    check("dec_lane1", dec_cnt[1], 21);
    check("dec_lane3", dec_cnt[3], 3);
`endif
    check("dec_lane4", dec_cnt[4], 13);
    check("dec_lane2", dec_cnt[2], 0);
    res_lane_sel = 4'd9;
    @(negedge SCLK);
    check("sel9_center", res_center, 0);
    check("sel9_window", res_window, 0);
    res_lane_sel = 4'd15;
    @(negedge SCLK);
    check("sel15_center", res_center, 0);
    check("sel15_window", res_window, 0);

    // Level held high after completion must not restart the sweep.
    repeat (10) @(negedge SCLK);
    check("hold_busy", busy, 0);
    check("hold_resp", int'(rdlvl_resp), 'h1FF);
    check("hold_no_reload", load_cnt[0], 1);

    rdlvl_en = 1'b0;
    @(negedge SCLK);
    check("drop_resp", int'(rdlvl_resp), 0);
    check("drop_err", int'(rd_training_error), 0);

    training_pattern = 8'h3C;
    rdlvl_en = 1'b1;
    n = 0;
    while (!rd_load[6] && n < 20000) begin
      @(negedge SCLK);
      n++;
    end
    check("abort_lane6_load", int'(rd_load[6]), 1);
    repeat (5) @(negedge SCLK);
    rdlvl_en = 1'b0;
    @(negedge SCLK);
    check("abort_busy", busy, 0);
    check("abort_resp", int'(rdlvl_resp), 0);
    pulses_before = 0;
    for (int l = 0; l < NL; l++) pulses_before += load_cnt[l] + mv_cnt[l];
    repeat (20) @(negedge SCLK);
    pulses_after = 0;
    for (int l = 0; l < NL; l++) pulses_after += load_cnt[l] + mv_cnt[l];
    check("abort_no_pulses", pulses_after - pulses_before, 0);
    res_lane_sel = 4'd6;
    @(negedge SCLK);
    check("abort_keep_center6", res_center, 45);
    check("abort_keep_window6", res_window, 11);
    res_lane_sel = 4'd5;
    @(negedge SCLK);
    check("abort_center5", res_center, exp_c[5]);

    lo[8] = 5; hi[8] = 20; exp_c[8] = 13; exp_w[8] = 16;
    rdlvl_en = 1'b1;
    @(negedge SCLK);
    check("rerun_busy", busy, 1);
    check("rerun_load_lane0", int'(rd_load), 1);
    wait_idle(20000);
    check("run3_resp", int'(rdlvl_resp), 'h1FF);
    check("run3_err", int'(rd_training_error), 'h00C);
    check_lanes("run3");

    rdlvl_en = 1'b0;
    @(negedge SCLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
